hash_table_probe: RTL
=====================

# hash_table_probe

Transposition-table probe stage placed directly downstream of the `mix_hash` stage. It accepts a 32-bit mixed hash key and searches a small on-chip key table using linear probing. It reports hit or miss and the slot index, and on a miss it can insert the key. The search engine uses it to skip board states it has already evaluated.

## Interface
Parameters:
- `INDEX_BITS`, 6: table holds 2^INDEX_BITS entries; home slot = `key[INDEX_BITS-1:0]`
- `MAX_PROBES`, 4: maximum slots examined per request (1..2^INDEX_BITS)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; clears state, table valid bits and all outputs
- `start` in 1: request strobe; sampled only in IDLE
- `key` in 32: hash key, connected to the mixer's `out`; latched when `start` is accepted
- `insert` in 1: latched with `start`; 1 = write the key on a miss, 0 = lookup only
- `clear` in 1: strobe; invalidates the whole table; sampled only in IDLE
- `busy` out 1: high whenever state ≠ IDLE
- `done` out 1: one-cycle pulse when a request resolves
- `hit` out 1: key was found
- `full` out 1: MAX_PROBES slots were examined with no match and no empty slot
- `slot` out INDEX_BITS: slot that matched, or was written, or was the last one examined
- `hit_count`, `miss_count` out 16: statistics counters (see Configuration)

## Operation
- Storage: 2^INDEX_BITS entries, each holding a valid bit and a 32-bit tag. Entries are flops, so reads are combinational.
- FSM states: IDLE, PROBE, CLEAR.
- IDLE:
  - `clear` → CLEAR and `ptr` = 0.
  - Else `start` → PROBE; latch `key` and `insert`; probe counter `p` = 0.
  - If `clear` and `start` are both high, `clear` wins and `start` is dropped.
- PROBE: the current index is `(key[INDEX_BITS-1:0] + p) mod 2^INDEX_BITS`, so probing wraps from the top slot to 0. Each cycle, with the entry at that index:
  - Valid and tag == key: `hit`=1, `full`=0, `slot`=index, `done` pulses, → IDLE.
  - Not valid: `hit`=0, `full`=0, `slot`=index, `done` pulses, → IDLE. If `insert`, write the tag and set valid at the same edge.
  - Valid and tag ≠ key, with p == MAX_PROBES-1: `hit`=0, `full`=1, `slot`=index, `done` pulses, → IDLE. No write.
  - Otherwise p++ and stay in PROBE.
- CLEAR: clears `valid[ptr]` and increments `ptr` every cycle. Leaves to IDLE after the edge that clears the entry at 2^INDEX_BITS-1.
- `start` and `clear` are ignored while `busy` is high.
- `hit`, `full` and `slot` hold their values until the next `done`. All key values, including 0, are legal.
- Reset mid-operation: the FSM returns to IDLE immediately. Any pending write is abandoned, and all valid bits clear.

## Timing
- Reset values: `busy`=0, `done`=0, `hit`=0, `full`=0, `slot`=0, `hit_count`=0, `miss_count`=0, state IDLE, all valid bits 0.
- Latency: `start` sampled at edge 0; probe i is evaluated at edge 1+i; `done`, `hit`, `full` and `slot` are registered at that same edge.
  - Best case: `done` is high in the cycle after edge 1.
  - Worst case: `done` is high in the cycle after edge MAX_PROBES.
- `busy` rises at edge 0 and falls at the edge that raises `done`. A new `start` may be accepted during the `done` cycle.
- Clear takes exactly 2^INDEX_BITS cycles with `busy` high. `done` does not pulse for a clear.
- A table write and the result outputs update at the same edge, so the next request sees the inserted entry.

## Configuration
- `HASH_PROBE_STATS_EN` defined:
  - `hit_count` increments on each `done` with `hit`=1.
  - `miss_count` increments on each `done` with `hit`=0; this includes `full` results.
  - Both counters are 16-bit and saturate at 0xFFFF. They clear only on reset; `clear` does not affect them.
- `HASH_PROBE_STATS_EN` undefined: no counter logic is built, and both ports are tied to constant 0.

## Test plan
All scenarios use INDEX_BITS=6 and MAX_PROBES=4.
- Empty table, insert key 0x00000005 → `done` after edge 1, `hit`=0, `full`=0, `slot`=5. A lookup of the same key → `hit`=1, `slot`=5.
- Insert 0x45, 0x85, 0xC5 in turn → slots 6, 7, 8. Lookup 0xC5 → `hit`=1, `slot`=8, `done` after edge 4.
- With slots 5..8 occupied as above, insert 0x105 → `full`=1, `hit`=0, `slot`=8, `done` after edge 4. A following lookup of 0x105 → `full`=1, confirming no write occurred.
- Wrap-around: insert 0x3F then 0x7F → slots 63 and 0. Lookup 0x7F → `hit`=1, `slot`=0.
- Pulse `clear` together with `start` → the start is dropped and `busy` stays high for 64 cycles. A `start` pulsed during the clear is ignored. A lookup of 0x05 afterwards → `hit`=0.
- Assert `reset` low mid-PROBE → `busy`, `done`, `hit` and `slot` go to 0 immediately, with no clock edge needed. Lookup 0x05 afterwards → `hit`=0.
- With `HASH_PROBE_STATS_EN` defined → counters match the hits and misses produced by the scenarios above.

Source files
------------

// File: rtl/hash_table_probe.sv
// Linear-probing transposition-table probe: looks up a 32-bit key, optionally inserts on miss.
// Optional hit/miss statistics counters are built when HASH_PROBE_STATS_EN is defined.
module hash_table_probe #(
  parameter int INDEX_BITS = 6,
  parameter int MAX_PROBES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           key,
  input  logic                  insert,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic                  full,
  output logic [INDEX_BITS-1:0] slot,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_PROBE = INDEX_BITS'(MAX_PROBES - 1);
  localparam logic [INDEX_BITS-1:0] LAST_SLOT  = INDEX_BITS'(DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]            state;
  logic [31:0]           key_reg;
  logic                  insert_reg;
  logic [INDEX_BITS-1:0] p;
  logic [INDEX_BITS-1:0] ptr;
  logic [DEPTH-1:0]      valid;
  logic [31:0]           tags [DEPTH];

  logic [INDEX_BITS-1:0] idx;
  logic                  cur_valid;
  logic                  cur_match;
  logic                  last_probe;
  logic                  resolve;
  logic                  res_hit;
  logic                  do_write;

  // Index wraps naturally because the sum is truncated to INDEX_BITS.
  always_comb begin
    idx        = key_reg[INDEX_BITS-1:0] + p;
    cur_valid  = valid[idx];
    cur_match  = cur_valid && (tags[idx] == key_reg);
    last_probe = (p == LAST_PROBE);
    resolve    = (state == PROBE) && (!cur_valid || cur_match || last_probe);
    res_hit    = cur_match;
    do_write   = (state == PROBE) && !cur_valid && insert_reg;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      key_reg    <= '0;
      insert_reg <= 1'b0;
      p          <= '0;
      ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
          end else if (start) begin
            state      <= PROBE;
            key_reg    <= key;
            insert_reg <= insert;
            p          <= '0;
          end
        end
        PROBE: begin
          if (resolve) begin
            state <= IDLE;
          end else begin
            p <= p + 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_SLOT) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits reset with the block; a pending insert is lost on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (state == CLEAR) begin
      valid[ptr] <= 1'b0;
    end else if (do_write) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tags are only meaningful behind a set valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      tags[idx] <= key_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      hit  <= 1'b0;
      full <= 1'b0;
      slot <= '0;
    end else begin
      done <= resolve;
      if (resolve) begin
        hit  <= res_hit;
        full <= cur_valid && !cur_match;
        slot <= idx;
      end
    end
  end

`ifdef HASH_PROBE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  // Saturating counters; untouched by the table clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (resolve) begin
      if (res_hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule
